// File: rtl/booth_divider_seq_if.sv
// Handshake/operand bundle between the control unit and booth_divider_seq.
// DIV_SIGNED_CTRL_EN adds the signed_op select.
interface booth_divider_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   Q;
    logic [WIDTH-1:0]   M;
`ifdef DIV_SIGNED_CTRL_EN
    logic               signed_op;
`endif
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, Q, M,
`ifdef DIV_SIGNED_CTRL_EN
        output signed_op,
`endif
        input  busy, done, div_by_zero, result
    );

    modport slave (
        input  start, Q, M,
`ifdef DIV_SIGNED_CTRL_EN
        input  signed_op,
`endif
        output busy, done, div_by_zero, result
    );
endinterface

// File: rtl/booth_divider_seq.sv
// Sequential non-restoring signed divider, result = {remainder, quotient}.
// Optional DIV_SIGNED_CTRL_EN selects unsigned/signed per operation.
module booth_divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              clear_n,
    booth_divider_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     qr_q, qr_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;
    logic                 dz_q, dz_d;
    logic [2*WIDTH-1:0]   res_q, res_d;

    logic                 sgn;
    logic                 q_neg;
    logic                 m_neg;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       step;
    logic [WIDTH:0]       a_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     quo_fix;

`ifdef DIV_SIGNED_CTRL_EN
    assign sgn = bus.signed_op;
`else
    assign sgn = 1'b1;
`endif

    assign q_neg   = sgn & bus.Q[WIDTH-1];
    assign m_neg   = sgn & bus.M[WIDTH-1];
    // A may wrap transiently after the shift; the post-add value always fits.
    assign shifted = {a_q[WIDTH-1:0], qr_q[WIDTH-1]};
    assign step    = a_q[WIDTH] ? shifted + {1'b0, m_q}
                                : shifted - {1'b0, m_q};
    assign a_fix   = a_q[WIDTH] ? a_q + {1'b0, m_q} : a_q;
    assign rem_fix = negr_q ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
    assign quo_fix = negq_q ? -qr_q : qr_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    negq_d = q_neg ^ m_neg;
                    negr_d = q_neg;
                    dz_d   = 1'b0;
                    if (bus.M == '0) begin
                        dz_d    = 1'b1;
                        res_d   = {bus.Q, {WIDTH{1'b1}}};
                        state_d = DONE;
                    end else begin
                        a_d     = '0;
                        qr_d    = q_neg ? -bus.Q : bus.Q;
                        m_d     = m_neg ? -bus.M : bus.M;
                        cnt_d   = CW'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                a_d   = step;
                qr_d  = {qr_q[WIDTH-2:0], ~step[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                a_d     = a_fix;
                res_d   = {rem_fix, quo_fix};
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            qr_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy        = (state_q == CALC) || (state_q == FIX);
    assign bus.done        = (state_q == DONE);
    assign bus.div_by_zero = dz_q;
    assign bus.result      = res_q;
endmodule

// File: tb/tb_booth_divider_seq.sv
// Directed self-checking bench for booth_divider_seq (WIDTH=32).
// Table vectors plus hand-written multi-cycle corner sequences.
module tb_booth_divider_seq;
    localparam int W = 32;

    logic clock;
    logic clear_n;
    int   checks;
    int   errors;

    booth_divider_seq_if #(.WIDTH(W)) bus ();

    booth_divider_seq #(.WIDTH(W)) dut (
        .clock  (clock),
        .clear_n(clear_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] q;
        logic [31:0] m;
        logic        sop;
        logic [63:0] res;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives start for one edge, then counts edges after the accepting
    // edge until done (bounded) and the cycles busy was seen high.
    task automatic do_div(input logic [31:0] q, input logic [31:0] m,
                          input logic sop, output int lat,
                          output int busy_n);
        bus.Q     = q;
        bus.M     = m;
`ifdef DIV_SIGNED_CTRL_EN
        bus.signed_op = sop;
`else
        if (sop !== 1'b1) $display("note: sop ignored in signed-only build");
`endif
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_n++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    int lat;
    int bn;

    initial begin
        checks    = 0;
        errors    = 0;
        clear_n   = 1'b0;
        bus.start = 1'b0;
        bus.Q     = '0;
        bus.M     = '0;
`ifdef DIV_SIGNED_CTRL_EN
        bus.signed_op = 1'b1;
`endif
        vecs[0]  = '{32'd100, 32'd7, 1'b1, {32'h2, 32'hE}, 1'b0};
        vecs[1]  = '{32'hFFFFFF9C, 32'd7, 1'b1,
                     {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0};
        vecs[2]  = '{32'd100, 32'hFFFFFFF9, 1'b1,
                     {32'h2, 32'hFFFFFFF2}, 1'b0};
        vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1,
                     {32'h0, 32'h80000000}, 1'b0};
        vecs[4]  = '{32'h12345678, 32'h0, 1'b1,
                     {32'h12345678, 32'hFFFFFFFF}, 1'b1};
        vecs[5]  = '{32'd7, 32'd100, 1'b1, {32'h7, 32'h0}, 1'b0};
        vecs[6]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1,
                     {32'hFFFFFFFF, 32'h3}, 1'b0};
        vecs[7]  = '{32'h7FFFFFFF, 32'd1, 1'b1,
                     {32'h0, 32'h7FFFFFFF}, 1'b0};
        vecs[8]  = '{32'h80000000, 32'd2, 1'b1,
                     {32'h0, 32'hC0000000}, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b1,
                     {32'h0, 32'h1}, 1'b0};
        vecs[10] = '{32'h0, 32'hFFFFFFFD, 1'b1, {32'h0, 32'h0}, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 32'h0, 1'b1,
                     {32'hFFFFFFFF, 32'hFFFFFFFF}, 1'b1};
        vecs[12] = '{32'h80000000, 32'h7FFFFFFF, 1'b1,
                     {32'hFFFFFFFF, 32'hFFFFFFFF}, 1'b0};

        repeat (2) @(posedge clock);
        #1;
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_dz", 64'(bus.div_by_zero), 64'd0);
        chk("reset_result", bus.result, 64'd0);
        clear_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 13; i++) begin
            do_div(vecs[i].q, vecs[i].m, vecs[i].sop, lat, bn);
            chk($sformatf("v%0d_result", i), bus.result, vecs[i].res);
            chk($sformatf("v%0d_dz", i), 64'(bus.div_by_zero),
                64'(vecs[i].dz));
            chk($sformatf("v%0d_latency", i), 64'(lat),
                vecs[i].dz ? 64'd0 : 64'd33);
            chk($sformatf("v%0d_busy_cycles", i), 64'(bn),
                vecs[i].dz ? 64'd0 : 64'd33);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
            chk($sformatf("v%0d_hold", i), bus.result, vecs[i].res);
            chk($sformatf("v%0d_dz_hold", i), 64'(bus.div_by_zero),
                64'(vecs[i].dz));
            @(negedge clock);
        end

        // Reset in the middle of CALC abandons the divide.
        bus.Q = 32'd100;
        bus.M = 32'd7;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("mid_busy_before_reset", 64'(bus.busy), 64'd1);
        clear_n = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_result", bus.result, 64'd0);
        clear_n = 1'b1;
        @(negedge clock);
        do_div(32'd9, 32'd3, 1'b1, lat, bn);
        chk("after_abort_result", bus.result, {32'd0, 32'd3});
        chk("after_abort_latency", 64'(lat), 64'd33);

        // start during CALC is ignored; then held into DONE -> back-to-back.
        @(negedge clock);
        bus.Q = 32'd100;
        bus.M = 32'd7;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        bus.Q = 32'd50;
        bus.M = 32'd5;
        bus.start = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        bus.start = 1'b0;
        lat = 7;
        while (!bus.done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("ignored_start_latency", 64'(lat), 64'd33);
        chk("ignored_start_result", bus.result, {32'd2, 32'd14});
        do_div(32'd50, 32'd5, 1'b1, lat, bn);
        chk("b2b_busy_cycles", 64'(bn), 64'd33);
        chk("b2b_latency", 64'(lat), 64'd33);
        chk("b2b_result", bus.result, {32'd0, 32'd10});

`ifdef DIV_SIGNED_CTRL_EN
        @(negedge clock);
        do_div(32'hFFFFFFFE, 32'd2, 1'b0, lat, bn);
        chk("unsigned_result", bus.result, {32'd0, 32'h7FFFFFFF});
        @(negedge clock);
        do_div(32'hFFFFFFFE, 32'd2, 1'b1, lat, bn);
        chk("signed_result", bus.result, {32'd0, 32'hFFFFFFFF});
        @(negedge clock);
        do_div(32'hFFFFFFFF, 32'd0, 1'b0, lat, bn);
        chk("unsigned_dz_result", bus.result,
            {32'hFFFFFFFF, 32'hFFFFFFFF});
        chk("unsigned_dz_flag", 64'(bus.div_by_zero), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_divider_seq.md
Name: booth_divider_seq

Overview:
- Sequential signed integer divider; the inverse operation of the datapath's multiplier.
- Feeds the CPU's HI/LO registers for the DIV instruction.
- Result packing matches the multiplier output: remainder in the upper half (HI), quotient in the lower half (LO).
- Non-restoring algorithm, one quotient bit per clock, start/busy/done handshake with the control unit.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- clear_n  input  1  synchronous reset, active-low; sampled on rising edge of clock.
- start  input  1  request a divide; sampled only in IDLE or DONE.
- Q  input  WIDTH  dividend (two's complement); captured on the accepting edge.
- M  input  WIDTH  divisor (two's complement); captured on the accepting edge.
- busy  output  1  high in CALC and FIX.
- done  output  1  one-cycle pulse, high only in DONE.
- div_by_zero  output  1  set with done when captured M == 0; holds until next accepted start.
- result  output  2*WIDTH  {remainder, quotient}; holds until next accepted start.

Behaviour:
- Reset (clear_n=0 at an edge): state=IDLE; busy=0, done=0, div_by_zero=0, result=0, internal accumulator/counter=0.
- Reset applies in any state and abandons an in-flight divide.
- States:
  - IDLE: start=1 -> capture operands and signs. If M==0 -> DONE; else load magnitudes, counter=WIDTH, go to CALC.
  - CALC: one non-restoring step per cycle. Shift {A,Qr} left; A += |M| if A negative, else A -= |M|; new quotient LSB = ~A[msb]. Counter decrements; at 0 -> FIX. Takes exactly WIDTH cycles.
  - FIX: if A negative, A += |M|. Negate quotient if dividend and divisor signs differ. Negate remainder if dividend is negative. Register result; go to DONE.
  - DONE: done=1 for one cycle -> IDLE. A start in DONE is accepted as if in IDLE (back-to-back, no bubble).
- start is ignored in CALC/FIX; operands are not re-sampled.
- Latency from the accepting edge to done visible:
  - Normal divide: WIDTH+1 edges (33 for WIDTH=32).
  - Divide by zero: 1 edge.
- Semantics: truncate toward zero; remainder sign = dividend sign; |remainder| < |divisor|.
- Divide by zero: quotient = all ones, remainder = Q, div_by_zero=1.
- Overflow (Q = most negative, M = -1): quotient = most negative value (wraps), remainder = 0; no flag.
- Internal accumulator A is WIDTH+1 bits. Magnitude of the most negative value is handled as unsigned WIDTH bits.

Optional Feature:
- Macro: DIV_SIGNED_CTRL_EN.
- Defined: adds input port signed_op (1 bit), captured with the operands.
  - signed_op=0 -> operands treated as unsigned; no sign fix-up in FIX.
  - signed_op=1 -> signed behaviour above.
  - Divide by zero is handled identically in both modes.
- Undefined: no signed_op port; always signed.

Test Plan:
- Q=100, M=7, start pulse -> busy 1 for 33 cycles, done at edge 33; result = {0x00000002, 0x0000000E}.
- Q=-100 (0xFFFFFF9C), M=7 -> result = {0xFFFFFFFE, 0xFFFFFFF2}; Q=100, M=-7 -> result = {0x00000002, 0xFFFFFFF2}.
- Q=0x80000000, M=0xFFFFFFFF -> result = {0x00000000, 0x80000000}, div_by_zero=0. Q=0x12345678, M=0 -> done one cycle after start, div_by_zero=1, result = {0x12345678, 0xFFFFFFFF}.
- Start 100/7, pull clear_n low at cycle 10 of CALC -> next edge: IDLE, busy=0, done=0, result=0. A new start of 9/3 then yields {0, 3} with full latency.
- Start asserted during CALC with other operands -> ignored; original result returned. Start held in DONE with 50/5 -> accepted, busy the next cycle, second result {0, 10}.
- With DIV_SIGNED_CTRL_EN: Q=0xFFFFFFFE, M=2, signed_op=0 -> {0, 0x7FFFFFFF}; signed_op=1 -> {0, 0xFFFFFFFF}.
